fft_peak_detect: RTL
====================

# fft_peak_detect

Streaming consumer for the FFT output interface (`vld` / `new_fft` / signed I/Q, natural bin order). Per bin, it computes |X|²; per frame, it reports the peak bin and total energy. It checks frame alignment against the `new_fft` marker and sits directly downstream of the FFT top as the first spectral-analysis block.

## Interface
Parameters:
- `IN_W`, 20, width of the incoming signed I/Q (the FFT output width).
- `LEN`, 256, bins per frame; must be a power of 2, at least 4.
- `IDX_W` (localparam), `$clog2(LEN)`.
- `PWR_W` (localparam), `2*IN_W`, unsigned bin-power width; holds (-2^(IN_W-1))²·2 exactly.
- `ENG_W` (localparam), `PWR_W + IDX_W`, frame-energy width; cannot overflow.

Ports:
- `mclk`, in, 1, single clock.
- `i_init`, in, 1, reset: synchronous, active-high.
- `i_vld`, in, 1, input bin valid.
- `i_new_fft`, in, 1, qualified by `i_vld`; marks bin 0 of a frame.
- `i_I`, in, `IN_W`, signed real part.
- `i_Q`, in, `IN_W`, signed imaginary part.
- `o_bin_vld`, out, 1, per-bin power valid.
- `o_bin_idx`, out, `IDX_W`, bin index of `o_bin_pwr`.
- `o_bin_pwr`, out, `PWR_W`, I²+Q², unsigned.
- `o_vld`, out, 1, one-cycle strobe when a frame result is ready.
- `o_peak_idx`, out, `IDX_W`, index of the max-power bin.
- `o_peak_pwr`, out, `PWR_W`, power of that bin.
- `o_energy`, out, `ENG_W`, sum of all `LEN` bin powers.
- `o_frame_err`, out, 1, one-cycle strobe on an alignment violation.

## Operation
- **State machine: SEEK / RUN.**
  - Reset state is SEEK.
  - SEEK: samples without `i_new_fft` are discarded and produce no `o_bin_vld`. `i_vld & i_new_fft` is accepted as bin 0, and the state moves to RUN.
  - RUN: each `i_vld` is accepted; the bin counter advances 0..LEN-1. `i_vld` gaps of any length are legal and freeze everything.
- **Bin 0 with `i_new_fft` inside RUN (counter ≠ 0).**
  - Pulse `o_frame_err`.
  - Abandon the partial frame; no `o_vld` for it.
  - Treat the sample as bin 0 of a new frame.
- **Bin 1..LEN-1 without `i_new_fft`:** normal.
- **First valid after bin LEN-1 lacking `i_new_fft`.**
  - Pulse `o_frame_err`.
  - Discard the sample and go to SEEK.
  - The finished frame is still reported.
- **Power per bin:** I² and Q² are computed signed, exact, no rounding. Their sum is unsigned `PWR_W`.
- **Peak tracking:**
  - Bin 0 loads the peak.
  - Later bins replace it only if strictly greater, so ties keep the lowest index.
- **Energy:** bin 0 loads the accumulator; later bins add to it.
- **Result outputs:** `o_peak_idx`, `o_peak_pwr` and `o_energy` update only with `o_vld` and hold until the next `o_vld`.
- **Per-bin stream:** `o_bin_*` is emitted for every accepted sample, including bins of abandoned frames.

## Timing
- **Per-bin latency:** accepted sample at cycle t gives `o_bin_vld` at t+2. This is a fully pipelined 2-stage path: squares are registered at t+1, the sum at t+2. Throughput is 1 bin/cycle.
- **Frame result:**
  - Last bin (LEN-1) accepted at t gives `o_vld` at t+3, with the peak/energy accumulation at t+3 including that bin.
  - Back-to-back frames with no gap are supported. Bin 0 of the next frame reloading the accumulators at t+3 must not corrupt the result being reported in the same cycle.
- **Frame error:** the offending sample at t gives `o_frame_err` at t+1. A strobe for an abandoned frame never coexists with that frame's `o_vld`.
- **Reset:**
  - `i_init` high at edge e: at e all outputs are 0, the counter is 0, the state is SEEK, and the pipeline valids are cleared.
  - In-flight bins are dropped; no stale `o_bin_vld` or `o_vld` appears after `i_init`.
- **Simultaneous events:** `i_init` has priority over everything.

## Structure
- **Shared constants header:**
  - SEEK/RUN state encoding.
  - The width rules `PWR_W` and `ENG_W`, as functions of `IN_W` and `LEN`, reused by later spectral blocks.
- **Sub-module `cplx_mag_sq`:**
  - Parameter: `IN_W`. Ports: `mclk`, `i_init`, `i_vld`, `i_I`, `i_Q`, `o_vld`, `o_pwr`.
  - 2-cycle latency.
  - The bin index is carried alongside it in a matching 2-stage delay line in the top.
- **Top contents:** the counter/FSM, the index delay line, the peak/energy accumulators, and the result registers.

## Test plan
All scenarios use bench parameters `IN_W=8`, `LEN=8`.
1. **Single-tone frame.** Bin 3 = (100, -50), all other bins 0, `i_new_fft` on bin 0.
   - `o_bin_pwr`[3] = 12500.
   - `o_vld` 3 cycles after bin 7, with peak_idx 3, peak_pwr 12500, energy 12500.
2. **Extreme values.** All bins (-128, -128).
   - Every `o_bin_pwr` = 32768.
   - peak_idx 0 (tie rule); energy 262144, with no overflow in `ENG_W`=19.
3. **Gapped input.** Same frame as scenario 1 with random `i_vld` gaps, then back-to-back frames.
   - Results identical to scenario 1, one `o_vld` per frame.
   - No gap cycles emit `o_bin_vld`.
4. **Alignment errors.**
   - `i_new_fft` on bin 5: `o_frame_err` 1 cycle later, no `o_vld` for the partial frame, and the next 8 bins report normally.
   - Sample after bin 7 without `i_new_fft`: `o_frame_err`, SEEK, and the intervening samples are not emitted.
5. **Startup in SEEK.** Stream starting mid-frame (no `i_new_fft`).
   - No `o_bin_vld` until the first `i_new_fft`.
6. **Reset mid-frame.** `i_init` pulsed after bin 4.
   - All outputs 0 next cycle, no `o_vld` or `o_bin_vld` from the old frame.
   - The next `i_new_fft` frame reports correctly.

Source files
------------

// File: rtl/fft_peak_detect_pkg.sv
// Shared definitions for the spectral-analysis blocks: frame-alignment state
// encoding and the bin-power / frame-energy width rules.
package fft_peak_detect_pkg;

   typedef enum logic {
      SEEK = 1'b0,
      RUN  = 1'b1
   } state_t;

   // |X|^2 of a signed IN_W-bit pair is exact in 2*IN_W unsigned bits.
   function automatic int pwr_width(input int in_w);
      return 2 * in_w;
   endfunction

   function automatic int eng_width(input int in_w, input int len);
      return (2 * in_w) + $clog2(len);
   endfunction

endpackage

// File: rtl/fft_peak_detect_mag_sq.sv
// cplx_mag_sq: exact I^2 + Q^2 with a two-stage pipeline (squares, then sum).
module cplx_mag_sq
   import fft_peak_detect_pkg::*;
#(
   parameter int IN_W = 20,
   localparam int PWR_W = pwr_width(IN_W)
) (
   input  logic                   mclk,
   input  logic                   i_init,
   input  logic                   i_vld,
   input  logic signed [IN_W-1:0] i_I,
   input  logic signed [IN_W-1:0] i_Q,
   output logic                   o_vld,
   output logic [PWR_W-1:0]       o_pwr
);

   logic signed [PWR_W-1:0] i_ext_s;
   logic signed [PWR_W-1:0] q_ext_s;
   logic [PWR_W-1:0]        sq_i_r;
   logic [PWR_W-1:0]        sq_q_r;
   logic                    vld_d1_r;

   assign i_ext_s = {{IN_W{i_I[IN_W-1]}}, i_I};
   assign q_ext_s = {{IN_W{i_Q[IN_W-1]}}, i_Q};

   // Square stage then sum stage; each square is non-negative so the sum is unsigned.
   always_ff @(posedge mclk) begin
      if (i_init) begin
         vld_d1_r <= 1'b0;
         sq_i_r   <= {PWR_W{1'b0}};
         sq_q_r   <= {PWR_W{1'b0}};
         o_vld    <= 1'b0;
         o_pwr    <= {PWR_W{1'b0}};
      end else begin
         vld_d1_r <= i_vld;
         o_vld    <= vld_d1_r;
         if (i_vld) begin
            sq_i_r <= i_ext_s * i_ext_s;
            sq_q_r <= q_ext_s * q_ext_s;
         end
         if (vld_d1_r) begin
            o_pwr <= sq_i_r + sq_q_r;
         end
      end
   end

endmodule

// File: rtl/fft_peak_detect.sv
// Per-bin |X|^2 stream plus per-frame peak bin and total energy, with
// frame-alignment checking against the new_fft marker.
module fft_peak_detect
   import fft_peak_detect_pkg::*;
#(
   parameter int IN_W = 20,
   parameter int LEN  = 256,
   localparam int IDX_W = $clog2(LEN),
   localparam int PWR_W = pwr_width(IN_W),
   localparam int ENG_W = eng_width(IN_W, LEN)
) (
   input  logic                   mclk,
   input  logic                   i_init,
   input  logic                   i_vld,
   input  logic                   i_new_fft,
   input  logic signed [IN_W-1:0] i_I,
   input  logic signed [IN_W-1:0] i_Q,
   output logic                   o_bin_vld,
   output logic [IDX_W-1:0]       o_bin_idx,
   output logic [PWR_W-1:0]       o_bin_pwr,
   output logic                   o_vld,
   output logic [IDX_W-1:0]       o_peak_idx,
   output logic [PWR_W-1:0]       o_peak_pwr,
   output logic [ENG_W-1:0]       o_energy,
   output logic                   o_frame_err
);

   localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LEN - 1);

   state_t             state_r;
   state_t             state_nx_s;
   logic [IDX_W-1:0]   cnt_r;
   logic [IDX_W-1:0]   cnt_nx_s;
   logic               acc_s;
   logic [IDX_W-1:0]   acc_idx_s;
   logic               err_s;
   logic [IDX_W-1:0]   idx_d1_r;
   logic [IDX_W-1:0]   idx_d2_r;
   logic [IDX_W-1:0]   peak_idx_r;
   logic [PWR_W-1:0]   peak_pwr_r;
   logic [ENG_W-1:0]   energy_r;
   logic [IDX_W-1:0]   peak_idx_nx_s;
   logic [PWR_W-1:0]   peak_pwr_nx_s;
   logic [ENG_W-1:0]   energy_nx_s;
   logic               frame_done_s;

   cplx_mag_sq #(.IN_W(IN_W)) u_mag_sq (
      .mclk   (mclk),
      .i_init (i_init),
      .i_vld  (acc_s),
      .i_I    (i_I),
      .i_Q    (i_Q),
      .o_vld  (o_bin_vld),
      .o_pwr  (o_bin_pwr)
   );

   assign o_bin_idx = idx_d2_r;

   // Alignment FSM: a counter of 0 in RUN means a frame just completed and bin 0 is due.
   always_comb begin
      state_nx_s = state_r;
      cnt_nx_s   = cnt_r;
      acc_s      = 1'b0;
      acc_idx_s  = IDX_ZERO;
      err_s      = 1'b0;
      case (state_r)
         SEEK: begin
            if (i_vld && i_new_fft) begin
               acc_s      = 1'b1;
               cnt_nx_s   = IDX_ONE;
               state_nx_s = RUN;
            end else begin
               state_nx_s = SEEK;
            end
         end
         RUN: begin
            if (!i_vld) begin
               state_nx_s = RUN;
            end else if (i_new_fft) begin
               acc_s    = 1'b1;
               cnt_nx_s = IDX_ONE;
               err_s    = (cnt_r != IDX_ZERO);
            end else if (cnt_r == IDX_ZERO) begin
               err_s      = 1'b1;
               state_nx_s = SEEK;
            end else begin
               acc_s     = 1'b1;
               acc_idx_s = cnt_r;
               cnt_nx_s  = cnt_r + IDX_ONE;
            end
         end
         default: begin
            state_nx_s = SEEK;
            cnt_nx_s   = IDX_ZERO;
         end
      endcase
   end

   // Running peak/energy including the bin now leaving the power pipeline.
   always_comb begin
      peak_idx_nx_s = peak_idx_r;
      peak_pwr_nx_s = peak_pwr_r;
      energy_nx_s   = energy_r;
      if (o_bin_vld) begin
         if (idx_d2_r == IDX_ZERO) begin
            peak_idx_nx_s = IDX_ZERO;
            peak_pwr_nx_s = o_bin_pwr;
            energy_nx_s   = {{IDX_W{1'b0}}, o_bin_pwr};
         end else begin
            if (o_bin_pwr > peak_pwr_r) begin
               peak_idx_nx_s = idx_d2_r;
               peak_pwr_nx_s = o_bin_pwr;
            end else begin
               peak_idx_nx_s = peak_idx_r;
               peak_pwr_nx_s = peak_pwr_r;
            end
            energy_nx_s = energy_r + {{IDX_W{1'b0}}, o_bin_pwr};
         end
      end else begin
         energy_nx_s = energy_r;
      end
   end

   assign frame_done_s = o_bin_vld && (idx_d2_r == IDX_LAST);

   // State, index delay line, accumulators and result registers.
   always_ff @(posedge mclk) begin
      if (i_init) begin
         state_r     <= SEEK;
         cnt_r       <= IDX_ZERO;
         idx_d1_r    <= IDX_ZERO;
         idx_d2_r    <= IDX_ZERO;
         peak_idx_r  <= IDX_ZERO;
         peak_pwr_r  <= {PWR_W{1'b0}};
         energy_r    <= {ENG_W{1'b0}};
         o_vld       <= 1'b0;
         o_peak_idx  <= IDX_ZERO;
         o_peak_pwr  <= {PWR_W{1'b0}};
         o_energy    <= {ENG_W{1'b0}};
         o_frame_err <= 1'b0;
      end else begin
         state_r     <= state_nx_s;
         cnt_r       <= cnt_nx_s;
         idx_d1_r    <= acc_idx_s;
         idx_d2_r    <= idx_d1_r;
         peak_idx_r  <= peak_idx_nx_s;
         peak_pwr_r  <= peak_pwr_nx_s;
         energy_r    <= energy_nx_s;
         o_vld       <= frame_done_s;
         o_frame_err <= err_s;
         if (frame_done_s) begin
            o_peak_idx <= peak_idx_nx_s;
            o_peak_pwr <= peak_pwr_nx_s;
            o_energy   <= energy_nx_s;
         end
      end
   end

endmodule
